// File: rtl/cache_pkg.sv
// Shared types and helpers for the 2-way set-associative data cache.
//   state_t   : controller states (IDLE, RD_MISS, WR_MEM)
//   get_index : set index field of a word address
//   get_tag   : tag field of a word address
// The helpers work on a 32-bit container so that ADDR_W may be overridden
// up to ADDR_MAX_W; callers cast the result to the field width they need.
package cache_pkg;

  localparam int ADDR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_MEM
  } state_t;

  function automatic logic [ADDR_MAX_W-1:0] get_index(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int index_w);
    return addr & ((ADDR_MAX_W'(1) << index_w) - ADDR_MAX_W'(1));
  endfunction

  function automatic logic [ADDR_MAX_W-1:0] get_tag(input logic [ADDR_MAX_W-1:0] addr,
                                                     input int index_w);
    return addr >> index_w;
  endfunction

endpackage

// File: rtl/cache_system_2way_if.sv
// Core-side and memory-side bus of the cache subsystem.
//   cpu_re/cpu_we/cpu_addr/cpu_wdata : request from the core
//   cpu_rdata/stall                  : response to the core
//   mem_re/mem_we/mem_addr/mem_wdata : request to the backing memory
//   mem_rdata/mem_ready              : completion from the backing memory
// Modports:
//   slave  : the cache itself
//   master : the environment around it (core plus backing memory)
interface cache_system_2way_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpu_re;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, stall, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, stall, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid bit, tag and data word.
//   clk, rst : clock and synchronous active-high reset (clears valid bits)
//   index    : set selected for both lookup and write
//   tag      : tag compared on lookup and stored on write
//   hit      : selected set is valid and its tag matches
//   valid    : valid bit of the selected set
//   rdata    : data word of the selected set
//   we       : write strobe; sets valid and stores tag and wr_data
//   wr_data  : data word stored on write
module cache_way_array #(
  parameter int SETS   = 4,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(SETS)-1:0]    index,
  input  logic [TAG_W-1:0]           tag,
  output logic                       hit,
  output logic                       valid,
  output logic [DATA_W-1:0]          rdata,
  input  logic                       we,
  input  logic [DATA_W-1:0]          wr_data
);
  logic [SETS-1:0]   valid_bits;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS];

  assign valid = valid_bits[index];
  assign hit   = valid && (tag_mem[index] == tag);
  assign rdata = data_mem[index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (we) begin
      valid_bits[index] <= 1'b1;
    end
  end

  // NOTE: tag/data storage is deliberately not reset; a cleared valid bit
  // already hides stale contents, and leaving it out keeps these as plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_system_2way.sv
// 2-way set-associative, write-through, no-write-allocate, read-allocate
// data cache (one word per line) with true-LRU replacement, in front of a
// variable-latency backing memory.
//   clk, rst   : clock and synchronous active-high reset
//   bus        : core and memory handshake signals (slave modport)
//   hit_count  : saturating count of read hits
//   miss_count : saturating count of read misses
module cache_system_2way
  import cache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int SETS   = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  cache_system_2way_if.slave bus,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  state_t state, state_next;

  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic [SETS-1:0]    lru;          // per set: the least-recently-used way

  logic [ADDR_W-1:0]  lookup_addr;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  logic [1:0]         way_hit;
  logic [1:0]         way_valid;
  logic [1:0]         way_we;
  logic [DATA_W-1:0]  way_rdata [2];
  logic [DATA_W-1:0]  wr_data;

  logic hit_any, hit_way, victim_way;
  logic lru_we, lru_val;
  logic hit_inc, miss_inc;
  logic latch_addr, latch_wdata;

  // While an access is outstanding the latched address drives the lookup, so
  // the fill/update on mem_ready targets the set of the original request.
  assign lookup_addr = (state == IDLE) ? bus.cpu_addr : req_addr;
  assign index       = INDEX_W'(get_index(32'(lookup_addr), INDEX_W));
  assign tag         = TAG_W'(get_tag(32'(lookup_addr), INDEX_W));

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way_array #(
      .SETS   (SETS),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .index   (index),
      .tag     (tag),
      .hit     (way_hit[w]),
      .valid   (way_valid[w]),
      .rdata   (way_rdata[w]),
      .we      (way_we[w]),
      .wr_data (wr_data)
    );
  end

  // A line is only ever allocated on a miss, so at most one way can match.
  assign hit_any    = |way_hit;
  assign hit_way    = ~way_hit[0];
  assign victim_way = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru[index];

  assign bus.mem_addr  = req_addr;
  assign bus.mem_wdata = req_wdata;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    bus.stall     = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.cpu_rdata = '0;
    way_we        = '0;
    wr_data       = bus.mem_rdata;
    lru_we        = 1'b0;
    lru_val       = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    latch_addr    = 1'b0;
    latch_wdata   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.cpu_we) begin
          bus.stall   = 1'b1;
          latch_addr  = 1'b1;
          latch_wdata = 1'b1;
          state_next  = WR_MEM;
        end else if (bus.cpu_re) begin
          if (hit_any) begin
            bus.cpu_rdata = way_rdata[hit_way];
            lru_we        = 1'b1;
            lru_val       = ~hit_way;
            hit_inc       = 1'b1;
          end else begin
            bus.stall  = 1'b1;
            latch_addr = 1'b1;
            miss_inc   = 1'b1;
            state_next = RD_MISS;
          end
        end
      end

      RD_MISS: begin
        bus.mem_re = 1'b1;
        bus.stall  = 1'b1;
        if (bus.mem_ready) begin
          bus.stall          = 1'b0;
          bus.cpu_rdata      = bus.mem_rdata;
          way_we[victim_way] = 1'b1;
          lru_we             = 1'b1;
          lru_val            = ~victim_way;
          state_next         = IDLE;
        end
      end

      WR_MEM: begin
        bus.mem_we = 1'b1;
        bus.stall  = 1'b1;
        wr_data    = req_wdata;
        if (bus.mem_ready) begin
          bus.stall = 1'b0;
          if (hit_any) begin
            way_we[hit_way] = 1'b1;
            lru_we          = 1'b1;
            lru_val         = ~hit_way;
          end
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      if (latch_addr)  req_addr  <= bus.cpu_addr;
      if (latch_wdata) req_wdata <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         lru        <= '0;
    else if (lru_we) lru[index] <= lru_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + 1'b1;
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_system_2way.sv
// Scoreboard bench for cache_system_2way: stimulus tasks push expected read
// data and expected memory requests into queues; a monitor pops and compares
// them whenever the DUT completes a read or raises a memory request.
module tb_cache_system_2way;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int SETS    = 4;
  localparam int CNT_W   = 16;
  localparam int MEM_LAT = 3;

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } mem_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_system_2way_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  cache_system_2way_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

  logic [CNT_W-1:0] hit_count, miss_count;
  logic [1:0]       hit_count2, miss_count2;

  cache_system_2way #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_system_2way #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2), .hit_count(hit_count2), .miss_count(miss_count2)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [DATA_W-1:0] rd_q [$];
  mem_exp_t          mem_q [$];
  logic [DATA_W-1:0] model_mem [1 << ADDR_W];

  bit mem_auto     = 1'b1;
  bit manual_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Backing memory: answers MEM_LAT cycles after the request first appears.
  initial begin : mem_model
    int cnt;
    bit busy;
    for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = 32'hAAAA_0000 | 32'(i);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        busy = 1'b0;
      end else if (!mem_auto) begin
        busy = 1'b0;
        if (manual_pulse) begin
          manual_pulse  = 1'b0;
          bus.mem_ready = 1'b1;
          bus.mem_rdata = 32'hDEAD_BEEF;
        end
      end else if (!rst && (bus.mem_re || bus.mem_we)) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 0;
        end
        cnt++;
        if (cnt > MEM_LAT) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) model_mem[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = model_mem[bus.mem_addr];
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Second memory for the narrow-counter instance, fixed latency of one.
  initial begin : mem_model2
    bit seen;
    bus2.mem_ready = 1'b0;
    bus2.mem_rdata = '0;
    seen = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus2.mem_ready) begin
        bus2.mem_ready = 1'b0;
        seen = 1'b0;
      end else if (!rst && bus2.mem_re) begin
        if (seen) begin
          bus2.mem_ready = 1'b1;
          bus2.mem_rdata = 32'hBBBB_0000 | 32'(bus2.mem_addr);
        end
        seen = 1'b1;
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin : monitor
    bit req_seen;
    mem_exp_t e;
    logic [DATA_W-1:0] exp_rd;
    req_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_seen = 1'b0;
      end else begin
        if ((bus.mem_re || bus.mem_we) && !req_seen) begin
          req_seen = 1'b1;
          if (mem_q.size() == 0) begin
            check_cnt++;
            $display("FAIL mem_req: unexpected request at addr 0x%03h", bus.mem_addr);
          end else begin
            e = mem_q.pop_front();
            check("mem_req_is_write", 64'(bus.mem_we), 64'(e.is_wr));
            check("mem_req_exclusive", 64'(bus.mem_re & bus.mem_we), 64'(0));
            check("mem_addr", 64'(bus.mem_addr), 64'(e.a));
            if (e.is_wr) check("mem_wdata", 64'(bus.mem_wdata), 64'(e.d));
          end
        end
        if (!bus.mem_re && !bus.mem_we) req_seen = 1'b0;
        if (bus.cpu_re && !bus.cpu_we && !bus.stall) begin
          if (rd_q.size() == 0) begin
            check_cnt++;
            $display("FAIL cpu_rdata: unexpected read completion, addr 0x%03h", bus.cpu_addr);
          end else begin
            exp_rd = rd_q.pop_front();
            check($sformatf("cpu_rdata_%03h", bus.cpu_addr), 64'(bus.cpu_rdata), 64'(exp_rd));
          end
        end
      end
    end
  end

  // All stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp,
                         input bit hit);
    int n = 0;
    rd_q.push_back(exp);
    if (!hit) mem_q.push_back('{is_wr: 1'b0, a: addr, d: '0});
    bus.cpu_addr = addr;
    bus.cpu_re   = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.stall) break;
      n++;
      if (n > 100) begin
        check_cnt++;
        $display("FAIL read_timeout: addr 0x%03h still stalled after %0d cycles", addr, n);
        break;
      end
    end
    check($sformatf("rd_stall_cycles_%03h", addr), 64'(n), hit ? 64'(0) : 64'(1 + MEM_LAT));
    @(posedge clk); #1;
    bus.cpu_re = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input bit with_re);
    int n = 0;
    mem_q.push_back('{is_wr: 1'b1, a: addr, d: data});
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    bus.cpu_we    = 1'b1;
    bus.cpu_re    = with_re;
    forever begin
      @(negedge clk);
      if (!bus.stall) break;
      if (n == 1) begin
        check("wr_mem_we", 64'(bus.mem_we), 64'(1));
        check("wr_mem_re", 64'(bus.mem_re), 64'(0));
      end
      n++;
      if (n > 100) begin
        check_cnt++;
        $display("FAIL write_timeout: addr 0x%03h still stalled after %0d cycles", addr, n);
        break;
      end
    end
    check($sformatf("wr_stall_cycles_%03h", addr), 64'(n), 64'(1 + MEM_LAT));
    @(posedge clk); #1;
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
  endtask

  task automatic do_read2(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    int n = 0;
    bus2.cpu_addr = addr;
    bus2.cpu_re   = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus2.stall) break;
      n++;
      if (n > 100) begin
        check_cnt++;
        $display("FAIL read2_timeout: addr 0x%03h", addr);
        break;
      end
    end
    check("sat_cpu_rdata", 64'(bus2.cpu_rdata), 64'(exp));
    @(posedge clk); #1;
    bus2.cpu_re = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int h, input int m);
    check({tag, "_hit_count"},  64'(hit_count),  64'(h));
    check({tag, "_miss_count"}, 64'(miss_count), 64'(m));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.cpu_re  = 1'b0; bus.cpu_we  = 1'b0; bus.cpu_addr  = '0; bus.cpu_wdata  = '0;
    bus2.cpu_re = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_stall",     64'(bus.stall),     64'(0));
    check("rst_mem_re",    64'(bus.mem_re),    64'(0));
    check("rst_mem_we",    64'(bus.mem_we),    64'(0));
    check("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
    check_counts("rst", 0, 0);
    @(posedge clk); #1;

    // Miss with L=3, then hit on the same word
    do_read(10'h005, 32'hAAAA_0005, 1'b0);
    check_counts("first_miss", 0, 1);
    do_read(10'h005, 32'hAAAA_0005, 1'b1);
    check_counts("first_hit", 1, 1);

    // Three misses in set 1: the third evicts 0x001, which then misses again
    do_reset();
    do_read(10'h001, 32'hAAAA_0001, 1'b0);
    do_read(10'h005, 32'hAAAA_0005, 1'b0);
    do_read(10'h009, 32'hAAAA_0009, 1'b0);
    do_read(10'h001, 32'hAAAA_0001, 1'b0);
    check_counts("evict_lru", 0, 4);
    do_read(10'h009, 32'hAAAA_0009, 1'b1);

    // A hit on 0x001 makes 0x005 the LRU victim for 0x009
    do_reset();
    do_read(10'h001, 32'hAAAA_0001, 1'b0);
    do_read(10'h005, 32'hAAAA_0005, 1'b0);
    do_read(10'h001, 32'hAAAA_0001, 1'b1);
    do_read(10'h009, 32'hAAAA_0009, 1'b0);
    do_read(10'h001, 32'hAAAA_0001, 1'b1);
    do_read(10'h005, 32'hAAAA_0005, 1'b0);
    check_counts("lru_touch", 2, 4);

    // Write-through, no-write-allocate, then write update of a resident line
    do_reset();
    do_write(10'h002, 32'h0000_1234, 1'b0);
    do_read(10'h002, 32'h0000_1234, 1'b0);
    do_write(10'h002, 32'h0000_5678, 1'b0);
    do_read(10'h002, 32'h0000_5678, 1'b1);
    check_counts("write_path", 1, 1);

    // Read and write together: write wins, and it still does not allocate
    do_write(10'h003, 32'hCAFE_F00D, 1'b1);
    check_counts("re_we_both", 1, 1);
    do_read(10'h003, 32'hCAFE_F00D, 1'b0);
    check_counts("re_we_after", 1, 2);

    // Reset in the middle of a read miss, then a stray mem_ready
    do_reset();
    mem_auto = 1'b0;
    mem_q.push_back('{is_wr: 1'b0, a: 10'h00D, d: '0});
    bus.cpu_addr = 10'h00D;
    bus.cpu_re   = 1'b1;
    @(negedge clk);
    check("abort_idle_stall", 64'(bus.stall), 64'(1));
    @(negedge clk);
    check("abort_rdmiss_mem_re", 64'(bus.mem_re), 64'(1));
    @(posedge clk); #1;
    rst        = 1'b1;
    bus.cpu_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_re", 64'(bus.mem_re), 64'(0));
    check("abort_stall",  64'(bus.stall),  64'(0));
    check_counts("abort", 0, 0);
    manual_pulse = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("stray_ready_stall",     64'(bus.stall),     64'(0));
    check("stray_ready_mem_re",    64'(bus.mem_re),    64'(0));
    check("stray_ready_mem_we",    64'(bus.mem_we),    64'(0));
    check("stray_ready_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
    check_counts("stray_ready", 0, 0);
    @(posedge clk); #1;
    mem_auto = 1'b1;
    @(posedge clk); #1;
    do_read(10'h00D, 32'hAAAA_000D, 1'b0);
    check_counts("after_abort", 0, 1);

    // Counter saturation on the CNT_W=2 instance: one miss, five hits
    for (int i = 0; i < 6; i++) do_read2(10'h007, 32'hBBBB_0007);
    check("sat_hit_count",  64'(hit_count2),  64'(3));
    check("sat_miss_count", 64'(miss_count2), 64'(1));

    repeat (2) @(posedge clk);
    check("rd_queue_drained",  64'(rd_q.size()),  64'(0));
    check("mem_queue_drained", 64'(mem_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/cache_system_2way.md
Name: cache_system_2way

Overview:
- Parametrised successor to the single-level cache + data-memory subsystem.
- 2-way set-associative, write-through, no-write-allocate, read-allocate data cache with one word per line.
- Talks to a variable-latency backing memory through a req/ready handshake and stalls the core while an access is outstanding.
- Adds true-LRU replacement and saturating read hit/miss counters.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data word width.
- SETS, 4, number of sets; must be a power of two, ≥2.
- CNT_W, 16, width of the performance counters.
- Derived (localparam, not overridable): INDEX_W = log2(SETS); TAG_W = ADDR_W - INDEX_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_re  in  1  read request.
- cpu_we  in  1  write request; takes priority if asserted together with cpu_re.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid when cpu_re=1 and stall=0.
- stall  out  1  core must hold cpu_* stable while high.
- mem_re  out  1  memory read request.
- mem_we  out  1  memory write request.
- mem_addr  out  ADDR_W  memory address; equals the latched request address.
- mem_wdata  out  DATA_W  memory write data; equals the latched write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse for the outstanding mem request.
- hit_count  out  CNT_W  saturating count of read hits.
- miss_count  out  CNT_W  saturating count of read misses.

Behaviour:
- Address split: index = cpu_addr[INDEX_W-1:0], tag = cpu_addr[ADDR_W-1:INDEX_W]. Per set: 2 × {valid, tag, data} plus one lru bit, which names the least-recently-used way.
- Reset: state=IDLE, all valid and lru bits=0, counters=0. Outputs stall, mem_re, mem_we=0; mem_addr, mem_wdata=0; cpu_rdata=0 when not hitting.
- Reset mid-miss or mid-write aborts the access. mem_re/mem_we drop in the cycle after the reset edge, and any later mem_ready is ignored.
- FSM states: IDLE, RD_MISS, WR_MEM.
- IDLE, read hit (cpu_re, cpu_we=0, a valid way's tag matches):
  - Combinational: cpu_rdata = hit way's data, stall=0.
  - Registered: lru[set] = other way; hit_count increments.
- IDLE, read miss:
  - stall=1 combinationally.
  - Latch addr; go to RD_MISS; miss_count increments once per miss.
- RD_MISS:
  - mem_re=1, stall=1 until mem_ready.
  - On the mem_ready cycle: cpu_rdata = mem_rdata, stall=0, and fill the victim way with valid=1, tag, data.
  - Victim selection: way0 if invalid, else way1 if invalid, else the lru way. Then lru[set] = other way; return to IDLE.
- IDLE, cpu_we: stall=1 combinationally; latch addr and wdata; go to WR_MEM.
- WR_MEM:
  - mem_we=1, stall=1 until mem_ready.
  - On the mem_ready cycle: if a way hits, update its data and set lru to the other way; a miss does not allocate. stall=0; return to IDLE.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss or write: 1 + L stall cycles, where L ≥ 1 is the number of cycles from mem request assertion to mem_ready.
- mem_ready in IDLE is ignored. mem_re and mem_we are never both high.
- After a stall drops, a request held in the same cycle is a new request. The core must deassert or change the request on the cycle stall=0, otherwise it is re-issued.
- Counters saturate at 2^CNT_W-1 and never wrap. Writes are not counted.
- No request (re=we=0) in IDLE: no state change, stall=0.

Decomposition:
- Package cache_pkg: the state enum (IDLE, RD_MISS, WR_MEM) and the address-split helper functions (get_tag, get_index).
- Sub-module cache_way_array (one instance per way): valid/tag/data storage. It has a synchronous clear on rst, a combinational lookup (hit, rdata) and a single write port.
- The top module holds the FSM, the lru bits, the request latches and the counters.

Test Plan:
- Reset, then read 0x005 with mem_ready at L=3 returning 0xAAAA0005 → stall for 4 cycles; cpu_rdata=0xAAAA0005 on the release cycle; miss_count=1. Re-read 0x005 → stall=0, same data, hit_count=1.
- SETS=4: read 0x001, 0x005, 0x009 (all set 1), then re-read 0x001 → the third miss evicts 0x001 (LRU); the final read misses; miss_count=4.
- Read 0x001, read 0x005, re-read 0x001 (hit, so 0x005 becomes LRU), read 0x009 → 0x005 is evicted and 0x001 still hits.
- Write 0x002=0x1234 with no prior fill → mem_we with mem_addr=0x002 and mem_wdata=0x1234. A subsequent read of 0x002 misses (no-allocate). Write 0x002=0x5678 after the fill → the read hits and returns 0x5678.
- cpu_re and cpu_we both high on 0x003 → write path only: mem_we=1, mem_re=0.
- Assert rst mid-RD_MISS, then pulse mem_ready → no fill, state IDLE, counters 0, mem_re=0. Force counter saturation via CNT_W=2 with 5 hits → hit_count=3.
